fifo_wr_arbiter: RTL

//  Write-side controller for the async FIFO; sits entirely in the wclk domain.

---
 rtl/fifo_wr_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Write side of the async FIFO: round-robin burst arbiter, binary/gray write pointer, full flag.
// Optional WR_ALMOST_FULL_EN adds the registered walmost_full output.
module fifo_wr_arbiter #(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int AFULL_TH = 2
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         gnt,
    input  logic [ADDRSIZE:0]       wq2_rptr,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [ADDRSIZE-1:0]     waddr,
    output logic [ADDRSIZE:0]       wptr,
    output logic                    wfull,
`ifdef WR_ALMOST_FULL_EN
    output logic                    walmost_full,
`endif
    output logic                    dbg_state
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_rr_ptr;
    logic [OW-1:0]     w_owner_next;
    logic [OW-1:0]     w_rr_next;
    logic [OW-1:0]     w_pick;
    logic              w_pick_valid;
    logic [OW-1:0]     w_owner_sel;
    logic [OW-1:0]     w_owner_inc;
    logic              w_sel_req;
    logic              w_sel_last;
    logic              w_winc;

    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wgray;
    logic              r_wfull;
    logic [ADDRSIZE:0] w_wbinnext;
    logic [ADDRSIZE:0] w_wgraynext;
    logic [ADDRSIZE:0] w_full_cmp;

    function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] x);
        if (int'(x) >= NREQ - 1) return '0;
        return x + OW'(1);
    endfunction

    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return OW'(s);
    endfunction

    // Search starts at rr_ptr so the most recently served requester is last in line.
    always_comb begin
        w_pick       = r_rr_ptr;
        w_pick_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_pick_valid && req[rr_idx(r_rr_ptr, k)]) begin
                w_pick       = rr_idx(r_rr_ptr, k);
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_owner_sel = (r_state == S_BURST) ? r_owner : w_pick;
    assign w_sel_req   = req[w_owner_sel];
    assign w_sel_last  = req_last[w_owner_sel];
    assign w_owner_inc = inc_mod(w_owner_sel);
    assign w_winc      = wrst_n & w_sel_req & ~r_wfull;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_rr_ptr <= w_rr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_owner_next = w_pick;
                    // A stalled last word still locks the owner until it transfers.
                    if (w_winc && w_sel_last) w_rr_next    = w_owner_inc;
                    else                      w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (!req[r_owner] || (w_winc && w_sel_last)) begin
                    w_state_next = S_IDLE;
                    w_rr_next    = w_owner_inc;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (w_winc) gnt[w_owner_sel] = 1'b1;
        winc      = w_winc;
        wdata     = req_data[int'(w_owner_sel)*DSIZE +: DSIZE];
        dbg_state = r_state;
    end

    assign w_wbinnext  = r_wbin + (ADDRSIZE+1)'(w_winc);
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;
    assign w_full_cmp  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_wfull <= 1'b0;
        end else begin
            r_wbin  <= w_wbinnext;
            r_wgray <= w_wgraynext;
            r_wfull <= (w_wgraynext == w_full_cmp);
        end
    end

    assign waddr = r_wbin[ADDRSIZE-1:0];
    assign wptr  = r_wgray;
    assign wfull = r_wfull;

`ifdef WR_ALMOST_FULL_EN
    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [ADDRSIZE:0] w_rbin_sync;
    logic [ADDRSIZE:0] w_used;
    logic [ADDRSIZE:0] w_free;
    logic              r_walmost_full;

    always_comb begin
        w_rbin_sync = '0;
        for (int i = 0; i <= ADDRSIZE; i++) w_rbin_sync[i] = ^(wq2_rptr >> i);
    end

    // Occupancy fits in ADDRSIZE+1 bits because the writer never passes rptr+DEPTH.
    assign w_used = w_wbinnext - w_rbin_sync;
    assign w_free = DEPTH - w_used;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) r_walmost_full <= 1'b0;
        else         r_walmost_full <= (w_free <= (ADDRSIZE+1)'(AFULL_TH));
    end

    assign walmost_full = r_walmost_full;
`endif

endmodule
